// File: rtl/regfile_wb_sched.sv
// Write-back port arbiter and register scoreboard; optional sticky sb_err under SCB_ERR_CHK_EN.
// Grant to register file write: 1 cycle. No backpressure from the register file; issue stalls on busy rs1/rs2/rd.
module regfile_wb_sched #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 64,
    parameter int IDX_W   = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      iss_valid_i,
    input  logic                      iss_rs1_en_i,
    input  logic [IDX_W-1:0]          iss_rs1_index_i,
    input  logic                      iss_rs2_en_i,
    input  logic [IDX_W-1:0]          iss_rs2_index_i,
    input  logic                      iss_rd_en_i,
    input  logic [IDX_W-1:0]          iss_rd_index_i,
    output logic                      iss_ready_o,
    input  logic [NUM_REQ-1:0]        wb_valid_i,
    input  logic [NUM_REQ*IDX_W-1:0]  wb_index_i,
    input  logic [NUM_REQ*DATA_W-1:0] wb_data_i,
    output logic [NUM_REQ-1:0]        wb_ready_o,
    output logic                      rf_rd_en_o,
    output logic [IDX_W-1:0]          rf_rd_index_o,
    output logic [DATA_W-1:0]         rf_rd_data_o,
`ifdef SCB_ERR_CHK_EN
    output logic                      sb_idle_o,
    output logic                      sb_err_o
`else
    output logic                      sb_idle_o
`endif
);

    localparam int NREG  = 1 << IDX_W;
    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    logic [NREG-1:0]   busy_q, busy_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              rf_rd_en_q, rf_rd_en_d;
    logic [IDX_W-1:0]  rf_rd_index_q, rf_rd_index_d;
    logic [DATA_W-1:0] rf_rd_data_q, rf_rd_data_d;

    logic               gnt_vld;
    logic [PTR_W-1:0]   gnt_id;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [IDX_W-1:0]   gnt_idx;
    logic [DATA_W-1:0]  gnt_dat;
    logic               hazard;
    logic               iss_fire;
    logic               iss_set;

    function automatic logic [PTR_W-1:0] rr_wrap(input logic [PTR_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Search begins one past the last winner, so the last winner has lowest priority.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = rr_ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!gnt_vld && wb_valid_i[rr_wrap(rr_ptr_q, k)]) begin
                gnt_vld = 1'b1;
                gnt_id  = rr_wrap(rr_ptr_q, k);
            end
        end
        if (!rst_i) gnt_vld = 1'b0;
    end

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_dat = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt_vld && (gnt_id == PTR_W'(r))) begin
                gnt_oh[r] = 1'b1;
                gnt_idx   = wb_index_i[r*IDX_W +: IDX_W];
                gnt_dat   = wb_data_i[r*DATA_W +: DATA_W];
            end
        end
    end

    assign wb_ready_o = gnt_oh;

    assign hazard = (iss_rs1_en_i & busy_q[iss_rs1_index_i])
                  | (iss_rs2_en_i & busy_q[iss_rs2_index_i])
                  | (iss_rd_en_i  & busy_q[iss_rd_index_i]);

    assign iss_ready_o = rst_i & ~hazard;
    assign iss_fire    = iss_valid_i & iss_ready_o & iss_rd_en_i;
    assign iss_set     = iss_fire & (iss_rd_index_i != '0);

    // The clear lands on the same edge the register file is written, so no bypass is needed.
    always_comb begin
        busy_d = busy_q;
        if (rf_rd_en_q) busy_d[rf_rd_index_q] = 1'b0;
        if (iss_set) busy_d[iss_rd_index_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rr_ptr_d      = gnt_vld ? gnt_id : rr_ptr_q;
        rf_rd_en_d    = gnt_vld & (gnt_idx != '0);
        rf_rd_index_d = gnt_vld ? gnt_idx : rf_rd_index_q;
        rf_rd_data_d  = gnt_vld ? gnt_dat : rf_rd_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            busy_q        <= '0;
            rr_ptr_q      <= PTR_W'(NUM_REQ - 1);
            rf_rd_en_q    <= 1'b0;
            rf_rd_index_q <= '0;
            rf_rd_data_q  <= '0;
        end else begin
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            rf_rd_en_q    <= rf_rd_en_d;
            rf_rd_index_q <= rf_rd_index_d;
            rf_rd_data_q  <= rf_rd_data_d;
        end
    end

    assign rf_rd_en_o    = rf_rd_en_q;
    assign rf_rd_index_o = rf_rd_index_q;
    assign rf_rd_data_o  = rf_rd_data_q;
    assign sb_idle_o     = (busy_q == '0) & ~rf_rd_en_q;

`ifdef SCB_ERR_CHK_EN
    logic err_q, err_d;
    logic wb_unowned;
    logic iss_waw;

    // A write-back nobody is waiting for means a requester and the scoreboard disagree.
    assign wb_unowned = gnt_vld & (gnt_idx != '0) & ~busy_q[gnt_idx]
                      & ~(iss_set & (iss_rd_index_i == gnt_idx));
    assign iss_waw    = iss_fire & busy_q[iss_rd_index_i];
    assign err_d      = err_q | wb_unowned | iss_waw;

    always_ff @(posedge clk_i) begin
        if (!rst_i) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign sb_err_o = err_q;
`endif

    a_grant_onehot: assert property (@(posedge clk_i) $onehot0(wb_ready_o));
    a_grant_valid:  assert property (@(posedge clk_i) (wb_ready_o & ~wb_valid_i) == '0);

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
    localparam int N  = 3;
    localparam int DW = 64;
    localparam int IW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            iss_valid, iss_rs1_en, iss_rs2_en, iss_rd_en;
    logic [IW-1:0]   iss_rs1, iss_rs2, iss_rd;
    logic            iss_ready;
    logic [N-1:0]    wb_valid, wb_ready;
    logic [N*IW-1:0] wb_index;
    logic [N*DW-1:0] wb_data;
    logic            rf_en;
    logic [IW-1:0]   rf_idx;
    logic [DW-1:0]   rf_dat;
    logic            sb_idle;
`ifdef SCB_ERR_CHK_EN
    logic            sb_err;
`endif

    always #5 clk = ~clk;

    regfile_wb_sched #(.NUM_REQ(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk_i(clk), .rst_i(rst),
        .iss_valid_i(iss_valid),
        .iss_rs1_en_i(iss_rs1_en), .iss_rs1_index_i(iss_rs1),
        .iss_rs2_en_i(iss_rs2_en), .iss_rs2_index_i(iss_rs2),
        .iss_rd_en_i(iss_rd_en),   .iss_rd_index_i(iss_rd),
        .iss_ready_o(iss_ready),
        .wb_valid_i(wb_valid), .wb_index_i(wb_index), .wb_data_i(wb_data),
        .wb_ready_o(wb_ready),
        .rf_rd_en_o(rf_en), .rf_rd_index_o(rf_idx), .rf_rd_data_o(rf_dat),
`ifdef SCB_ERR_CHK_EN
        .sb_idle_o(sb_idle), .sb_err_o(sb_err)
`else
        .sb_idle_o(sb_idle)
`endif
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        else passed++;
    endtask

    // Reference model: scoreboard as a bit per register, pointer as a plain integer.
    bit          m_busy [32];
    int          m_rr;
    bit          m_en;
    logic [4:0]  m_idx;
    logic [63:0] m_dat;
    bit          m_err;
    bit          m_live = 1'b0;

    function automatic int exp_grant();
        if (!rst) return -1;
        for (int k = 1; k <= N; k++) begin
            if (wb_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit exp_ready();
        if (!rst) return 1'b0;
        return !((iss_rs1_en && m_busy[iss_rs1]) || (iss_rs2_en && m_busy[iss_rs2]) ||
                 (iss_rd_en && m_busy[iss_rd]));
    endfunction

    function automatic bit exp_idle();
        for (int i = 0; i < 32; i++) if (m_busy[i]) return 1'b0;
        return !m_en;
    endfunction

    always @(posedge clk) begin
        int         g;
        bit         fire, set;
        logic [4:0] gi;
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_rr = N - 1; m_en = 1'b0; m_idx = '0; m_dat = '0; m_err = 1'b0;
            m_live = 1'b1;
        end else begin
            g    = exp_grant();
            fire = iss_valid && exp_ready() && iss_rd_en;
            set  = fire && (iss_rd != 0);
            gi   = (g >= 0) ? wb_index[g*IW +: IW] : 5'd0;
            if (g >= 0 && gi != 0 && !m_busy[gi] && !(set && iss_rd == gi)) m_err = 1'b1;
            if (fire && m_busy[iss_rd]) m_err = 1'b1;
            if (m_en) m_busy[m_idx] = 1'b0;
            if (set) m_busy[iss_rd] = 1'b1;
            if (g >= 0) begin
                m_en  = (gi != 0);
                m_idx = gi;
                m_dat = wb_data[g*DW +: DW];
                m_rr  = g;
            end else begin
                m_en = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        if (m_live) begin
            g = exp_grant();
            chk("m_wb_ready", wb_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            chk("m_iss_ready", iss_ready, exp_ready());
            chk("m_rf_en", rf_en, m_en);
            chk("m_rf_idx", rf_idx, m_idx);
            chk("m_rf_dat", rf_dat, m_dat);
            chk("m_sb_idle", sb_idle, exp_idle());
`ifdef SCB_ERR_CHK_EN
            chk("m_sb_err", sb_err, m_err);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [2:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        rst = 1'b0;
        iss_valid = 0; iss_rs1_en = 0; iss_rs2_en = 0; iss_rd_en = 0;
        iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        wb_valid = 3'b111; wb_index = '0; wb_data = '0;

        // Reset held two cycles with every requester asking.
        tick();
        mid();
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_iss_ready", iss_ready, 0);
        chk("rst_rf_en", rf_en, 0);
        tick();
        rst = 1'b1; wb_valid = 3'b000;
        mid();
        chk("rel_sb_idle", sb_idle, 1);
        chk("rel_iss_ready", iss_ready, 1);
        chk("rel_rf_en", rf_en, 0);

        // Round-robin from rr_ptr=2, all targeting x0.
        tick();
        wb_valid = 3'b111;
        wb_data  = {64'h3, 64'h2, 64'h1};
        for (int i = 0; i < 6; i++) begin
            mid();
            chk("rr_grant", wb_ready, rr_exp[i]);
            tick();
        end
        wb_valid = 3'b000;

        // Write-back to x0 consumes the grant and writes nothing.
        wb_valid = 3'b100; wb_data = {64'hFFFF, 64'h0, 64'h0};
        mid();
        chk("idx0_grant", wb_ready, 3'b100);
        tick();
        wb_valid = 3'b000;
        mid();
        chk("idx0_rf_en", rf_en, 0);
        chk("idx0_sb_idle", sb_idle, 1);

        // RAW: rd=5 issues, then a reader of x5 stalls until the write lands.
        tick();
        iss_valid = 1; iss_rd_en = 1; iss_rd = 5;
        mid();
        chk("raw_issue_rd", iss_ready, 1);
        tick();
        iss_rd_en = 0; iss_rs1_en = 1; iss_rs1 = 5;
        wb_valid = 3'b010; wb_index = {5'd0, 5'd5, 5'd0};
        wb_data = {64'h0, 64'hDEAD_BEEF, 64'h0};
        mid();
        chk("raw_stall", iss_ready, 0);
        chk("raw_grant", wb_ready, 3'b010);
        tick();
        wb_valid = 3'b000;
        mid();
        chk("raw_rf_en", rf_en, 1);
        chk("raw_rf_idx", rf_idx, 5);
        chk("raw_rf_dat", rf_dat, 64'hDEAD_BEEF);
        chk("raw_still_stall", iss_ready, 0);
        tick();
        mid();
        chk("raw_release", iss_ready, 1);
        tick();
        iss_valid = 0; iss_rs1_en = 0;

        // WAW: second writer of x7 waits for the first write-back.
        iss_valid = 1; iss_rd_en = 1; iss_rd = 7;
        mid();
        chk("waw_first", iss_ready, 1);
        tick();
        mid();
        chk("waw_stall0", iss_ready, 0);
        tick();
        wb_valid = 3'b001; wb_index = {5'd0, 5'd0, 5'd7}; wb_data = {64'h0, 64'h0, 64'h77};
        mid();
        chk("waw_grant", wb_ready, 3'b001);
        chk("waw_stall1", iss_ready, 0);
        tick();
        wb_valid = 3'b000;
        mid();
        chk("waw_stall2", iss_ready, 0);
        chk("waw_rf_en", rf_en, 1);
        tick();
        mid();
        chk("waw_release", iss_ready, 1);
        tick();
        iss_valid = 0;

        // Clear of x7 and set of x8 on the same edge.
        wb_valid = 3'b100; wb_index = {5'd7, 5'd0, 5'd0}; wb_data = {64'h1234, 64'h0, 64'h0};
        mid();
        chk("sc_grant", wb_ready, 3'b100);
        tick();
        wb_valid = 3'b000;
        iss_valid = 1; iss_rd_en = 1; iss_rd = 8;
        mid();
        chk("sc_rf_en", rf_en, 1);
        chk("sc_issue8", iss_ready, 1);
        tick();
        iss_valid = 0; iss_rd_en = 0; iss_rs1_en = 1; iss_rs1 = 7;
        mid();
        chk("sc_x7_free", iss_ready, 1);
        chk("sc_not_idle", sb_idle, 0);
        tick();
        iss_rs2_en = 1; iss_rs2 = 8;
        mid();
        chk("sc_x8_busy", iss_ready, 0);
        tick();
        wb_valid = 3'b001; wb_index = {5'd0, 5'd0, 5'd8}; wb_data = {64'h0, 64'h0, 64'h88};
        tick();
        wb_valid = 3'b000;
        tick();
        mid();
        chk("sc_idle", sb_idle, 1);
        chk("sc_x8_free", iss_ready, 1);
        tick();
        iss_rs1_en = 0; iss_rs2_en = 0;

        // Write-back to x9 that nobody reserved.
`ifdef SCB_ERR_CHK_EN
        mid();
        chk("err_before", sb_err, 0);
        tick();
`endif
        wb_valid = 3'b010; wb_index = {5'd0, 5'd9, 5'd0}; wb_data = {64'h0, 64'h99, 64'h0};
        tick();
        wb_valid = 3'b000;
        mid();
        chk("x9_rf_idx", rf_idx, 9);
`ifdef SCB_ERR_CHK_EN
        chk("err_set", sb_err, 1);
        tick();
        tick();
        mid();
        chk("err_sticky", sb_err, 1);
`endif

        // Reset mid-operation drops the pending x3 reservation and request.
        tick();
        iss_valid = 1; iss_rd_en = 1; iss_rd = 3;
        tick();
        iss_valid = 0; iss_rd_en = 0;
        rst = 1'b0;
        wb_valid = 3'b001; wb_index = {5'd0, 5'd0, 5'd3};
        mid();
        chk("mrst_wb_ready", wb_ready, 0);
        chk("mrst_iss_ready", iss_ready, 0);
        tick();
        rst = 1'b1; wb_valid = 3'b000;
        mid();
        chk("mrst_idle", sb_idle, 1);
        chk("mrst_rf_en", rf_en, 0);
`ifdef SCB_ERR_CHK_EN
        chk("mrst_err", sb_err, 0);
`endif
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
